mem_access_unit: RTL and testbench

Parametrised MEM-stage data memory for the pipelined MIPS datapath, successor to the fixed 32-bit word-only memory stage. Holds an internal byte-enabled RAM and supports byte, halfword and word stores plus signed/unsigned loads with one-cycle registered read latency. It detects misaligned or reserved-size accesses and reports them through an error flag instead of touching memory. It sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_byte_ram.sv | 32 +++
 rtl/mem_access_unit.sv | 99 +++++++++
 tb/tb_mem_access_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: size encodings and lane helpers.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int unsigned NUM_BE = 4;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~lane[0];
      SIZE_WORD: ok = (lane == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [NUM_BE-1:0] byte_enable(input logic [1:0] size,
                                                    input logic [1:0] lane);
    logic [NUM_BE-1:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lane;
      SIZE_HALF: be = 4'b0011 << lane;
      SIZE_WORD: be = 4'b1111;
      default:   be = '0;
    endcase
    return be;
  endfunction

  // Right-justified store data copied into every lane it could land in.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] res;
    case (size)
      SIZE_BYTE: res = {4{wdata[7:0]}};
      SIZE_HALF: res = {2{wdata[15:0]}};
      default:   res = wdata;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic zero_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: res = zero_ext ? {24'h0, b} : {{24{b[7]}}, b};
      SIZE_HALF: res = zero_ext ? {16'h0, h} : {{16{h[15]}}, h};
      default:   res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the EX/MEM register and the data memory.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 9
);
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            size;
  logic                  load_unsigned;
  logic [31:0]           data_out;
  logic                  data_valid;
  logic                  mem_error;

  modport master (
    output address, write_data, mem_read, mem_write, size, load_unsigned,
    input  data_out, data_valid, mem_error
  );

  modport slave (
    input  address, write_data, mem_read, mem_write, size, load_unsigned,
    output data_out, data_valid, mem_error
  );
endinterface

// File: rtl/mem_byte_ram.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
module mem_byte_ram
  import mem_pkg::*;
#(
  parameter int unsigned WordAw = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [NUM_BE-1:0] be_i,
  input  logic              re_i,
  input  logic [WordAw-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned Depth = 2 ** WordAw;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < NUM_BE; k++) begin
        if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory: sized/aligned stores, sign/zero-extended loads, one-cycle read latency.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  localparam int unsigned WordAw = ADDR_WIDTH - 2;

  // Array power-up contents come from the simulator default; reset never clears the RAM.
  logic unused_init_zero;
  assign unused_init_zero = INIT_ZERO;

  logic [1:0]        lane;
  logic [WordAw-1:0] word_addr;
  logic              aligned;
  logic              ram_we;
  logic              ram_re;
  logic [NUM_BE-1:0] ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  assign lane      = bus.address[1:0];
  assign word_addr = bus.address[ADDR_WIDTH-1:2];
  assign aligned   = is_aligned(bus.size, lane);
  assign ram_be    = byte_enable(bus.size, lane);
  assign ram_wdata = replicate(bus.size, bus.write_data);
  assign ram_we    = ~reset & bus.mem_write & aligned;
  // A simultaneous store wins; the load is silently dropped.
  assign ram_re    = ~reset & bus.mem_read & ~bus.mem_write & aligned;

  mem_byte_ram #(
    .WordAw (WordAw)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .re_i    (ram_re),
    .addr_i  (word_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] data_out;

  always_comb begin
    valid_d = ram_re;
    error_d = ~reset & (bus.mem_read | bus.mem_write) & ~aligned;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    if (ram_re) begin
      lane_d = lane;
      size_d = bus.size;
      uns_d  = bus.load_unsigned;
    end
  end

  // Fresh result straight from the RAM register, otherwise the last result is held.
  always_comb begin
    data_out = hold_q;
    if (valid_q) data_out = load_extend(ram_rdata, lane_q, size_q, uns_q);
    hold_d = data_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      lane_q  <= 2'b00;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      error_q <= error_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = valid_q;
  assign bus.mem_error  = error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, randomized plus directed traffic.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    int unsigned due;
    logic        valid;
    logic        err;
    logic [31:0] dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  exp_t        exp_q[$];
  logic [7:0]  mdl_mem [512];
  logic [31:0] mdl_dout = 32'h0;

  mem_access_unit_if #(.ADDR_WIDTH(9)) bus ();

  mem_access_unit #(
    .ADDR_WIDTH (9),
    .INIT_ZERO  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One request per cycle; the model works on a flat byte array.
  task automatic step(input logic rst, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic [8:0] addr, input logic [31:0] wd, input logic uns);
    exp_t        e;
    int          a;
    int          n;
    logic [31:0] v;
    @(posedge clk);
    #1;
    reset             = rst;
    bus.mem_read      = rd;
    bus.mem_write     = wr;
    bus.size          = sz;
    bus.address       = addr;
    bus.write_data    = wd;
    bus.load_unsigned = uns;
    a       = int'(addr);
    n       = 1 << sz;
    e.due   = cyc + 1;
    e.valid = 1'b0;
    e.err   = 1'b0;
    if (rst) begin
      mdl_dout = 32'h0;
    end else if ((rd || wr) && (sz == 2'b11 || (a % n) != 0)) begin
      e.err = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < n; i++) mdl_mem[a + i] = wd[8*i +: 8];
    end else if (rd) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mdl_mem[a + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      mdl_dout = v;
      e.valid  = 1'b1;
    end
    e.dout = mdl_dout;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 9'h0, 32'h0, 1'b0);
  endtask

  // Monitor: compare outputs each cycle against the entry due on that edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("data_valid", 32'(bus.data_valid), 32'(e.valid));
        chk("mem_error", 32'(bus.mem_error), 32'(e.err));
        chk("data_out", bus.data_out, e.dout);
      end
    end
  end

  initial begin
    int          op;
    logic [1:0]  sz;
    logic [8:0]  ad;
    reset             = 1'b1;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.size          = 2'b00;
    bus.address       = 9'h0;
    bus.write_data    = 32'h0;
    bus.load_unsigned = 1'b0;

    step(1'b1, 1'b0, 1'b0, 2'b00, 9'h0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b10, 9'h0, 32'h0, 1'b0);
    for (int w = 0; w < 128; w++) step(1'b0, 1'b0, 1'b1, SIZE_WORD, 9'(w * 4), $urandom, 1'b0);

    step(1'b0, 1'b0, 1'b1, SIZE_WORD, 9'h010, 32'hDEADBEEF, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_WORD, 9'h010, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, SIZE_BYTE, 9'h013, 32'h00000080, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_BYTE, 9'h013, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_BYTE, 9'h013, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, SIZE_WORD, 9'h010, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, SIZE_WORD, 9'h010, 32'hDEADBEEF, 1'b0);
    step(1'b0, 1'b0, 1'b1, SIZE_HALF, 9'h012, 32'h00001234, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_WORD, 9'h010, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_HALF, 9'h012, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, SIZE_WORD, 9'h011, 32'h11111111, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_WORD, 9'h010, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_HALF, 9'h013, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_RSVD, 9'h010, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, SIZE_WORD, 9'h020, 32'h0000CAFE, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b0, SIZE_WORD, 9'h020, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, SIZE_WORD, 9'h040, 32'h000055AA, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_WORD, 9'h040, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, SIZE_WORD, 9'h0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, SIZE_WORD, 9'h040, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, SIZE_WORD, 9'h040, 32'hBAD0BAD0, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b0, SIZE_WORD, 9'h040, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, SIZE_BYTE, 9'h041, 32'h0, 1'b0);

    for (int t = 0; t < 600; t++) begin
      op = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      ad = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) ad = ad & ~9'((1 << sz) - 1);
      if (op <= 3)      step(1'b0, 1'b1, 1'b0, sz, ad, $urandom, 1'($urandom));
      else if (op <= 6) step(1'b0, 1'b0, 1'b1, sz, ad, $urandom, 1'($urandom));
      else if (op == 7) step(1'b0, 1'b1, 1'b1, sz, ad, $urandom, 1'($urandom));
      else if (op == 9 && $urandom_range(0, 3) == 0)
        step(1'b1, 1'($urandom), 1'($urandom), sz, ad, $urandom, 1'b0);
      else idle();
    end

    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
